// File: rtl/pipes.sv
// Shared execute-stage definitions for the iterative multiplier.
package pipes;

    localparam int unsigned MUL_WIDTH = 64;
    // Cycles from the request being sampled until done is high.
    localparam int unsigned MUL_DELAY = MUL_WIDTH + 1;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        MULW   = 3'd4
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_fixup.sv
// Output stage of the multiplier: applies the sign to the unsigned product,
// then selects the low half, the high half or the sign-extended word result.
module mul_fixup
    import pipes::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic [2:0]         op,
    input  logic               neg,
    input  logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] signed_product;

    // Negate when the operand signs differ, then pick the result field by op.
    always_comb begin
        signed_product = neg ? (~product + 1'b1) : product;
        result         = signed_product[WIDTH-1:0];
        case (op)
            MULH, MULHSU, MULHU: result = signed_product[2*WIDTH-1:WIDTH];
            MULW:                result = {{(WIDTH/2){product[WIDTH/2-1]}},
                                           product[WIDTH/2-1:0]};
            default:             ;
        endcase
    end

endmodule

// File: rtl/multiplier.sv
// Iterative radix-2 shift-add multiplier (RV64M MUL family), sign-magnitude.
// Fixed latency of WIDTH+1 cycles from request to done for every op.
module multiplier
    import pipes::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] c
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned HW = WIDTH / 2;

    mul_state_t          state;
    logic [CW-1:0]       count;
    logic [2*WIDTH-1:0]  product;
    logic [WIDTH-1:0]    mcand;
    logic                neg;
    logic [2:0]          op_q;

    logic                signed_a;
    logic                signed_b;
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    mag_a;
    logic [WIDTH-1:0]    mag_b;
    logic                neg_in;

    logic [WIDTH-1:0]    addend;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  product_next;
    logic [WIDTH-1:0]    result_next;

    // Operand magnitudes and result sign for the request presented in IDLE.
    always_comb begin
        signed_a = (op == MULH) || (op == MULHSU);
        signed_b = (op == MULH);
        a_neg    = signed_a & a[WIDTH-1];
        b_neg    = signed_b & b[WIDTH-1];
        if (op == MULW) begin
            mag_a  = {{HW{1'b0}}, a[HW-1:0]};
            mag_b  = {{HW{1'b0}}, b[HW-1:0]};
            neg_in = 1'b0;
        end else begin
            mag_a  = a_neg ? (~a + 1'b1) : a;
            mag_b  = b_neg ? (~b + 1'b1) : b;
            neg_in = a_neg ^ b_neg;
        end
    end

    // One shift-add step: conditionally add the multiplicand, shift right with carry in.
    always_comb begin
        addend       = product[0] ? mcand : '0;
        sum          = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        product_next = {sum, product[WIDTH-1:1]};
    end

    // The fixup sees the final step's product so done and c can be registered.
    mul_fixup #(
        .WIDTH (WIDTH)
    ) u_fixup (
        .op      (op_q),
        .neg     (neg),
        .product (product_next),
        .result  (result_next)
    );

    // Control FSM and datapath registers; dropping valid aborts like reset.
    always_ff @(posedge clk) begin
        if (reset || !valid) begin
            state   <= IDLE;
            count   <= '0;
            product <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            op_q    <= '0;
            done    <= 1'b0;
            c       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    product <= {{WIDTH{1'b0}}, mag_a};
                    mcand   <= mag_b;
                    neg     <= neg_in;
                    op_q    <= op;
                    count   <= CW'(WIDTH);
                    state   <= BUSY;
                end
                BUSY: begin
                    product <= product_next;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        c     <= result_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    c     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed-vector bench for the iterative multiplier (WIDTH=64).
module tb_multiplier;
    import pipes::*;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        done;
    logic [63:0] c;

    int unsigned checks;
    int unsigned errors;

    multiplier #(
        .WIDTH (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .op    (op),
        .a     (a),
        .b     (b),
        .done  (done),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; the following posedge is cycle 0.
    task automatic start_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        op    = o;
        a     = x;
        b     = y;
        valid = 1'b1;
    endtask

    // Wait for done (bounded), check latency and result, then drop valid
    // and confirm done and c return to zero.
    task automatic wait_done(input string tag, input logic [63:0] exp);
        int unsigned n;
        logic        seen;
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(MUL_DELAY));
        check({tag, "_c"}, c, exp);
        valid = 1'b0;
        @(negedge clk);
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        check({tag, "_c_clr"}, c, 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        valid  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(done), 64'd0);
        check("rst_c", c, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        start_op(MUL, 64'd3, 64'd5);
        wait_done("mul_3x5", 64'd15);

        start_op(MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        wait_done("mulh_min", 64'h4000_0000_0000_0000);

        start_op(MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("mulh_m1", 64'd0);

        start_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF);

        start_op(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done("mulhu", 64'd1);

        start_op(MULW, 64'h1234_5678_7FFF_FFFF, 64'd2);
        wait_done("mulw_pos", 64'hFFFF_FFFF_FFFF_FFFE);

        start_op(MULW, 64'hABCD_0000_FFFF_FFFF, 64'h9999_9999_0000_0003);
        wait_done("mulw_neg", 64'hFFFF_FFFF_FFFF_FFFD);

        start_op(MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("mul_m1", 64'd1);

        start_op(MULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
        wait_done("mulh_neg", 64'hFFFF_FFFF_FFFF_FFFF);

        start_op(3'd7, 64'd6, 64'd7);
        wait_done("op7_as_mul", 64'd42);

        // Abort: drop valid partway through, gap, then a fresh request.
        start_op(MUL, 64'd7, 64'd9);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_busy_done", 64'(done), 64'd0);
        end
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_gap_done", 64'(done), 64'd0);
            check("abort_gap_c", c, 64'd0);
        end
        start_op(MUL, 64'd6, 64'd7);
        wait_done("abort_then_mul", 64'd42);

        // Reset mid-operation with valid held; operation restarts afterward.
        start_op(MUL, 64'd11, 64'd13);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_c", c, 64'd0);
        reset = 1'b0;
        wait_done("after_rst", 64'd143);

        // Back-to-back: valid stays high across done into the next request.
        start_op(MUL, 64'd100, 64'd200);
        begin
            int unsigned n;
            n = 0;
            while (n < 200 && !done) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_lat", 64'(n), 64'(MUL_DELAY));
            check("b2b_first_c", c, 64'd20000);
            op = MULHU;
            a  = 64'hFFFF_FFFF_FFFF_FFFF;
            b  = 64'hFFFF_FFFF_FFFF_FFFF;
            // The cycle after done is the IDLE cycle that samples the new request.
            @(negedge clk);
            check("b2b_gap_done", 64'(done), 64'd0);
        end
        wait_done("b2b_second", 64'hFFFF_FFFF_FFFF_FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
